// File: rtl/serv_rf_ram_clr.sv
// Register-file RAM for the SERV RF RAM interface. It has 1-cycle read latency and
// read-before-write ordering. After reset, or on an i_clr request, it runs a sweep that
// zeroes every word.
module serv_rf_ram_clr #(
  parameter int unsigned width    = 8,
  parameter int unsigned csr_regs = 4,
  parameter int unsigned depth    = 32 * (32 + csr_regs) / width,
  localparam int unsigned aw      = $clog2(depth)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  output logic             o_busy,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  output logic [width-1:0] o_rdata
);

  typedef enum logic {StClear, StRun} state_e;

  // Terminal sweep address is depth-1, which need not be 2^aw-1.
  localparam logic [aw-1:0] LastAddr = aw'(depth - 1);

  state_e           state_q, state_d;
  logic [aw-1:0]    clr_addr_q, clr_addr_d;
  logic [width-1:0] rdata_q, rdata_d;

  logic [width-1:0] mem_q [depth];

  logic             mem_we;
  logic [aw-1:0]    mem_waddr;
  logic [width-1:0] mem_wdata;

  logic waddr_ok, raddr_ok;
  assign waddr_ok = 32'(i_waddr) < depth;
  assign raddr_ok = 32'(i_raddr) < depth;

  // Next-state and memory write port selection. The sweep owns the write port while clearing.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rdata_d    = '0;
    mem_we     = 1'b0;
    mem_waddr  = i_waddr;
    mem_wdata  = i_wdata;
    unique case (state_q)
      StClear: begin
        if (i_clr) begin
          // Restart the sweep; nothing is written on this edge.
          clr_addr_d = '0;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = clr_addr_q;
          mem_wdata = '0;
          if (clr_addr_q == LastAddr) begin
            state_d    = StRun;
            clr_addr_d = '0;
          end else begin
            clr_addr_d = clr_addr_q + aw'(1);
          end
        end
      end
      StRun: begin
        if (i_clr) begin
          // A clear request wins over a write on the same edge.
          state_d    = StClear;
          clr_addr_d = '0;
        end else begin
          mem_we = i_wen && waddr_ok;
          if (raddr_ok) rdata_d = mem_q[i_raddr];
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Control state and read data register. These are the only state elements that reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage array. It has no reset; only the sweep clears it.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign o_busy  = (state_q == StClear);
  assign o_rdata = rdata_q;

endmodule

// File: tb/tb_serv_rf_ram_clr.sv
// Self-checking bench for serv_rf_ram_clr. It runs directed steps plus randomized traffic.
// The expected values come from an array model with a "sweep edges remaining" count.
module tb_serv_rf_ram_clr;

  localparam int unsigned DEPTH = 144;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       busy;
  logic [7:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       wen = 1'b0;
  logic [7:0] raddr = '0;
  logic [7:0] rdata;

  int checks = 0;
  int failures = 0;

  // Reference model
  logic [7:0] mem_m [DEPTH];
  int         remaining = DEPTH;
  logic [7:0] exp_rdata = '0;

  serv_rf_ram_clr dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (clr),
    .o_busy  (busy),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .i_wen   (wen),
    .i_raddr (raddr),
    .o_rdata (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then check the outputs.
  task automatic step(input logic w, input logic [7:0] wa, input logic [7:0] wd,
                      input logic [7:0] ra, input logic c);
    wen = w; waddr = wa; wdata = wd; raddr = ra; clr = c;
    @(posedge clk);
    if (remaining > 0) begin
      exp_rdata = '0;
      if (c) remaining = DEPTH;
      else begin
        remaining--;
        if (remaining == 0) foreach (mem_m[k]) mem_m[k] = '0;
      end
    end else if (c) begin
      remaining = DEPTH;
      exp_rdata = '0;
    end else begin
      exp_rdata = (ra < DEPTH) ? mem_m[ra] : 8'h00;
      if (w && wa < DEPTH) mem_m[wa] = wd;
    end
    #1;
    chk("busy", 32'(busy), 32'(remaining > 0));
    chk("rdata", 32'(rdata), 32'(exp_rdata));
    wen = 1'b0; clr = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'd0);
    remaining = DEPTH;
    exp_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < int'(DEPTH); a++) step(1'b0, 8'd0, 8'd0, 8'(a), 1'b0);
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin
    foreach (mem_m[k]) mem_m[k] = '0;

    // Reset, then a full sweep; a write during the sweep must be ignored.
    apply_reset();
    idle(10);
    step(1'b1, 8'd5, 8'hFF, 8'd5, 1'b0);
    idle(int'(DEPTH) - 11);
    chk("sweep_done", 32'(busy), 32'd0);
    read_all();

    // Simple write then read.
    step(1'b1, 8'd7, 8'hA5, 8'd0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 8'd7, 1'b0);
    chk("rd7", 32'(rdata), 32'hA5);

    // Read-before-write on the same address.
    step(1'b1, 8'd10, 8'h11, 8'd0, 1'b0);
    step(1'b1, 8'd10, 8'h3C, 8'd10, 1'b0);
    chk("rbw_old", 32'(rdata), 32'h11);
    step(1'b0, 8'd0, 8'd0, 8'd10, 1'b0);
    chk("rbw_new", 32'(rdata), 32'h3C);

    // Out-of-range write and read.
    step(1'b1, 8'd150, 8'h77, 8'd150, 1'b0);
    step(1'b0, 8'd0, 8'd0, 8'd150, 1'b0);
    read_all();

    // Randomized traffic with occasional clear requests.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 159)), 8'($urandom),
           8'($urandom_range(0, 159)), ($urandom_range(0, 199) == 0));
    idle(int'(DEPTH) + 2);

    // Fill with a pattern, clear, restart the clear mid-sweep, then check everything reads zero.
    for (int a = 0; a < int'(DEPTH); a++) step(1'b1, 8'(a), 8'(a * 7 + 1), 8'(a), 1'b0);
    read_all();
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    idle(50);
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    idle(int'(DEPTH) - 1);
    chk("restart_busy", 32'(busy), 32'd1);
    idle(1);
    chk("restart_done", 32'(busy), 32'd0);
    read_all();

    // Asynchronous reset partway through a sweep.
    for (int a = 0; a < 20; a++) step(1'b1, 8'(a), 8'hC3, 8'd0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
    idle(60);
    apply_reset();
    idle(int'(DEPTH) + 1);
    read_all();

    // Asynchronous reset in RUN with a non-zero read value.
    step(1'b1, 8'd3, 8'h5A, 8'd0, 1'b0);
    step(1'b0, 8'd0, 8'd0, 8'd3, 1'b0);
    chk("pre_rst_rd", 32'(rdata), 32'h5A);
    apply_reset();
    idle(int'(DEPTH) + 1);
    read_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
